sha_stream_padder: RTL and testbench



---
 rtl/sha_pad_pkg.sv | 26 ++
 rtl/sha_pad_tail.sv | 46 ++++
 rtl/sha_stream_padder.sv | 190 +++++++++++++++++++
 tb/tb_sha_stream_padder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pad_pkg.sv
// sha_pad_pkg: shared types and helpers for the SHA stream padder.
//   block_bytes(big) : 64 (SHA-1/224/256) or 128 (SHA-384/512) byte blocks
//   len_bytes(big)   : 8 or 16 byte big-endian bit-length field
//   state_e          : padder control states
//   PAD_BYTE         : leading pad byte appended after the message
package sha_pad_pkg;

    typedef enum logic [2:0] {
        FILL,
        SEND,
        PAD,
        SEND_PRE,
        SEND_LAST
    } state_e;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    function automatic int block_bytes(input int big);
        return (big != 0) ? 128 : 64;
    endfunction

    function automatic int len_bytes(input int big);
        return (big != 0) ? 16 : 8;
    endfunction

endpackage

// File: rtl/sha_pad_tail.sv
// sha_pad_tail: combinational tail builder for the padder.
// Ports:
//   blk_i    : current block buffer, byte 0 in MSBs
//   ptr_i    : number of message bytes already in the buffer (0..BLOCK_BYTES)
//   len_i    : message length in bytes
//   padded_o : buffer with PAD_BYTE at ptr_i, zeros after, and the length
//              field in the tail when it fits
//   lenblk_o : all-zero block carrying only the length field
//   fits_o   : pad byte and length field both fit behind the message bytes
module sha_pad_tail
    import sha_pad_pkg::*;
#(
    parameter int BLOCK_BYTES = 64,
    parameter int LEN_BYTES   = 8,
    parameter int PTR_W       = 7
) (
    input  logic [BLOCK_BYTES*8-1:0] blk_i,
    input  logic [PTR_W-1:0]         ptr_i,
    input  logic [63:0]              len_i,
    output logic [BLOCK_BYTES*8-1:0] padded_o,
    output logic [BLOCK_BYTES*8-1:0] lenblk_o,
    output logic                     fits_o
);

    // Bit length {len,3'b0}, truncated or zero-extended to the field width.
    logic [LEN_BYTES*8-1:0] bitlen;
    assign bitlen = (LEN_BYTES*8)'({len_i, 3'b000});

    always_comb begin
        padded_o = '0;
        lenblk_o = '0;
        fits_o   = (32'(ptr_i) + 32'(LEN_BYTES) + 32'd1) <= 32'(BLOCK_BYTES);
        lenblk_o[LEN_BYTES*8-1:0] = bitlen;
        for (int unsigned b = 0; b < BLOCK_BYTES; b++) begin
            if (b < 32'(ptr_i)) begin
                padded_o[(BLOCK_BYTES-1-b)*8 +: 8] = blk_i[(BLOCK_BYTES-1-b)*8 +: 8];
            end else if (b == 32'(ptr_i)) begin
                padded_o[(BLOCK_BYTES-1-b)*8 +: 8] = PAD_BYTE;
            end
        end
        if (fits_o) begin
            padded_o[LEN_BYTES*8-1:0] = bitlen;
        end
    end

endmodule

// File: rtl/sha_stream_padder.sv
// sha_stream_padder: byte stream in, FIPS 180-4 padded blocks out.
// Optional feature macro: SHA_STREAM_PADDER_ERR_EN (adds sticky oerr output).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   tvalid/tready   : input beat handshake; tlast marks the final beat
//   tid             : message id, sampled on the first beat
//   tdata           : IBYTES payload bytes, first byte in MSBs
//   tbytes          : valid bytes on the tlast beat (0..IBYTES)
//   ovalid/oready   : output block handshake; olast marks the final block
//   oid, olen       : message id and byte length (olen wraps modulo 2^64)
//   oblock          : padded block, byte 0 in MSBs
//   oerr            : (macro only) malformed tbytes seen, sticky until rst
module sha_stream_padder
    import sha_pad_pkg::*;
#(
    parameter int IBYTES    = 1,
    parameter int BIG_BLOCK = 0,
    parameter int ID_W      = 32,
    localparam int BLOCK_BYTES = block_bytes(BIG_BLOCK),
    localparam int TB_W        = $clog2(IBYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tvalid,
    output logic                     tready,
    input  logic                     tlast,
    input  logic [ID_W-1:0]          tid,
    input  logic [8*IBYTES-1:0]      tdata,
    input  logic [TB_W-1:0]          tbytes,
    output logic                     ovalid,
    input  logic                     oready,
    output logic                     olast,
    output logic [ID_W-1:0]          oid,
    output logic [63:0]              olen,
    output logic [BLOCK_BYTES*8-1:0] oblock
`ifdef SHA_STREAM_PADDER_ERR_EN
    ,
    output logic                     oerr
`endif
);

    localparam int LEN_BYTES = len_bytes(BIG_BLOCK);
    localparam int PTR_W     = $clog2(BLOCK_BYTES + 1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(BLOCK_BYTES);

    state_e                   state_q, state_d;
    logic [BLOCK_BYTES*8-1:0] buf_q, buf_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [63:0]              len_q, len_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic                     in_msg_q, in_msg_d;
    logic                     run_q;

    logic                     accept;
    logic [31:0]              tb_ext;
    logic [PTR_W-1:0]         cnt;
    logic [BLOCK_BYTES*8-1:0] padded, lenblk;
    logic                     fits;

    assign tready = run_q && (state_q == FILL);
    assign accept = tvalid && tready;
    assign tb_ext = 32'(tbytes);

    // Non-last beats always carry IBYTES; oversized tbytes saturates.
    always_comb begin
        if (!tlast || tb_ext > 32'(IBYTES)) begin
            cnt = PTR_W'(IBYTES);
        end else begin
            cnt = PTR_W'(tbytes);
        end
    end

    sha_pad_tail #(
        .BLOCK_BYTES(BLOCK_BYTES),
        .LEN_BYTES  (LEN_BYTES),
        .PTR_W      (PTR_W)
    ) u_tail (
        .blk_i   (buf_q),
        .ptr_i   (ptr_q),
        .len_i   (len_q),
        .padded_o(padded),
        .lenblk_o(lenblk),
        .fits_o  (fits)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        id_d     = id_q;
        in_msg_d = in_msg_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    // ptr is always a multiple of IBYTES here, so the beat never straddles the block end.
                    for (int unsigned i = 0; i < IBYTES; i++) begin
                        if (i < 32'(cnt)) begin
                            buf_d[(BLOCK_BYTES-1-(32'(ptr_q)+i))*8 +: 8] = tdata[(IBYTES-1-i)*8 +: 8];
                        end
                    end
                    ptr_d = ptr_q + cnt;
                    len_d = len_q + 64'(cnt);
                    if (!in_msg_q) begin
                        id_d = tid;
                    end
                    if (tlast) begin
                        in_msg_d = 1'b0;
                        state_d  = PAD;
                    end else begin
                        in_msg_d = 1'b1;
                        if (ptr_q + PTR_W'(IBYTES) == PTR_FULL) begin
                            state_d = SEND;
                        end
                    end
                end
            end
            SEND: begin
                if (oready) begin
                    ptr_d   = '0;
                    buf_d   = '0;
                    state_d = FILL;
                end
            end
            PAD: begin
                buf_d   = padded;
                state_d = fits ? SEND_LAST : SEND_PRE;
            end
            SEND_PRE: begin
                if (oready) begin
                    buf_d = lenblk;
                    // A completely full data block left no room for the pad byte.
                    if (ptr_q == PTR_FULL) begin
                        buf_d[BLOCK_BYTES*8-1 -: 8] = PAD_BYTE;
                    end
                    state_d = SEND_LAST;
                end
            end
            SEND_LAST: begin
                if (oready) begin
                    ptr_d   = '0;
                    len_d   = '0;
                    buf_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            buf_q    <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
            id_q     <= '0;
            in_msg_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            id_q     <= id_d;
            in_msg_q <= in_msg_d;
            run_q    <= 1'b1;
        end
    end

    assign ovalid = (state_q == SEND) || (state_q == SEND_PRE) || (state_q == SEND_LAST);
    assign olast  = (state_q == SEND_LAST);
    assign oid    = id_q;
    assign olen   = len_q;
    assign oblock = buf_q;

`ifdef SHA_STREAM_PADDER_ERR_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && ((tlast && tb_ext > 32'(IBYTES)) ||
                                (!tlast && tb_ext != '0 && tb_ext != 32'(IBYTES)))) begin
            err_q <= 1'b1;
        end
    end
    assign oerr = err_q;
`endif

endmodule

// File: tb/tb_sha_stream_padder.sv
// tb_sha_stream_padder: three padder configurations driven side by side with
// random beats and random output back-pressure; expected blocks come from a
// message-level FIPS 180-4 padding model.
module tb_sha_stream_padder;

    localparam int NCFG = 3;
    localparam int CFG_IB  [NCFG] = '{1, 4, 16};
    localparam int CFG_BIG [NCFG] = '{0, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int IB  = CFG_IB[g];
        localparam int BIG = CFG_BIG[g];
        localparam int BB  = (BIG != 0) ? 128 : 64;
        localparam int LB  = (BIG != 0) ? 16 : 8;
        localparam int TBW = $clog2(IB + 1);

        logic              rst, tvalid, tready, tlast, ovalid, oready, olast;
        logic [31:0]       tid, oid;
        logic [8*IB-1:0]   tdata;
        logic [TBW-1:0]    tbytes;
        logic [63:0]       olen;
        logic [BB*8-1:0]   oblock;
`ifdef SHA_STREAM_PADDER_ERR_EN
        logic              oerr;
`endif

        logic [BB*8-1:0]   q_blk[$];
        logic [63:0]       q_len[$];
        logic [31:0]       q_id[$];
        bit                q_last[$];
        bit                stall = 1'b0;

        sha_stream_padder #(
            .IBYTES   (IB),
            .BIG_BLOCK(BIG),
            .ID_W     (32)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .tvalid(tvalid),
            .tready(tready),
            .tlast (tlast),
            .tid   (tid),
            .tdata (tdata),
            .tbytes(tbytes),
            .ovalid(ovalid),
            .oready(oready),
            .olast (olast),
            .oid   (oid),
            .olen  (olen),
            .oblock(oblock)
`ifdef SHA_STREAM_PADDER_ERR_EN
            ,
            .oerr  (oerr)
`endif
        );

        function automatic string tg(input string s);
            return $sformatf("c%0d/%s", g, s);
        endfunction

        task automatic chk_blk(input string tag, input logic [BB*8-1:0] got, input logic [BB*8-1:0] exp);
            for (int s = 0; s < BB/16; s++) begin
                expect_eq($sformatf("c%0d/%s[%0d]", g, tag, s), got[s*128 +: 128], exp[s*128 +: 128]);
            end
        endtask

        task automatic chk_reset();
            expect_eq(tg("rst tready"), tready, 0);
            expect_eq(tg("rst ovalid"), ovalid, 0);
            expect_eq(tg("rst olast"), olast, 0);
            expect_eq(tg("rst oid"), oid, 0);
            expect_eq(tg("rst olen"), olen, 0);
            chk_blk("rst oblock", oblock, '0);
`ifdef SHA_STREAM_PADDER_ERR_EN
            expect_eq(tg("rst oerr"), oerr, 0);
`endif
        endtask

        // Message-level padding: msg ++ 80 ++ zeros ++ big-endian bit length,
        // total a multiple of the block size, then cut into blocks.
        task automatic model_msg(input logic [31:0] id, input logic [7:0] msg[$]);
            logic [7:0]      p[$];
            logic [127:0]    bl;
            logic [BB*8-1:0] blk;
            logic [63:0]     L, cap;
            int              nblk;
            p = msg;
            L = 64'(msg.size());
            p.push_back(8'h80);
            while ((p.size() + LB) % BB != 0) p.push_back(8'h00);
            bl = {61'b0, L, 3'b000};
            for (int j = LB - 1; j >= 0; j--) p.push_back(bl[j*8 +: 8]);
            nblk = p.size() / BB;
            for (int k = 0; k < nblk; k++) begin
                for (int b = 0; b < BB; b++) blk[(BB-1-b)*8 +: 8] = p[k*BB + b];
                cap = 64'((k + 1) * BB);
                q_blk.push_back(blk);
                q_id.push_back(id);
                q_last.push_back(k == nblk - 1);
                q_len.push_back((k == nblk - 1 || L < cap) ? L : cap);
            end
        endtask

        task automatic put_beat(input logic [8*IB-1:0] d, input bit last, input logic [TBW-1:0] tb);
            int t;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tvalid = 1'b1;
            tdata  = d;
            tlast  = last;
            tbytes = tb;
            t = 0;
            while (!tready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!tready) expect_eq(tg("tready timeout"), tready, 1);
            @(negedge clk);
            tvalid = 1'b0;
        endtask

        task automatic drive_msg(input logic [31:0] id, input logic [7:0] msg[$], input bit zero_tail, input bit bad_mid);
            int              L, nbeats, pos, nb;
            logic [8*IB-1:0] d;
            logic [TBW-1:0]  tb;
            bit              last;
            L   = msg.size();
            pos = 0;
            model_msg(id, msg);
            if (L == 0)           nbeats = 1;
            else if (L % IB != 0) nbeats = L / IB + 1;
            else                  nbeats = L / IB + (zero_tail ? 1 : 0);
            for (int i = 0; i < nbeats; i++) begin
                last = (i == nbeats - 1);
                nb   = last ? L - pos : IB;
                for (int b = 0; b < IB; b++) d[(IB-1-b)*8 +: 8] = (b < nb) ? msg[pos + b] : 8'($urandom);
                tid = (i == 0) ? id : $urandom;
                if (last) begin
                    tb = TBW'(nb);
`ifndef SHA_STREAM_PADDER_ERR_EN
                    if (nb == IB && ((1 << TBW) - 1) > IB && $urandom_range(0, 1) == 1)
                        tb = TBW'($urandom_range(IB + 1, (1 << TBW) - 1));
`endif
                end else if (bad_mid && i == 0) begin
                    tb = TBW'(IB / 2);
                end else begin
`ifdef SHA_STREAM_PADDER_ERR_EN
                    tb = ($urandom_range(0, 1) == 1) ? TBW'(IB) : '0;
`else
                    tb = TBW'($urandom);
`endif
                end
                put_beat(d, last, tb);
`ifdef SHA_STREAM_PADDER_ERR_EN
                if (bad_mid && i == 0) expect_eq(tg("oerr set"), oerr, 1);
`endif
                pos += nb;
            end
            // Now one cycle after the tlast handshake: padding, then a block.
            expect_eq(tg("latency N+1 ovalid"), ovalid, 0);
            @(negedge clk);
            expect_eq(tg("latency N+2 ovalid"), ovalid, 1);
        endtask

        task automatic rand_msg(input int len, output logic [7:0] m[$]);
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
        endtask

        task automatic wait_drain();
            int t;
            t = 0;
            while (q_blk.size() != 0 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            expect_eq(tg("drain"), 128'(q_blk.size()), 0);
        endtask

        // Output side: random oready, per-block checks, hold-stability checks.
        initial begin
            bit              held;
            logic [BB*8-1:0] h_blk;
            logic [31:0]     h_id;
            held = 1'b0;
            forever begin
                @(negedge clk);
                oready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (rst) begin
                    held = 1'b0;
                end else begin
                    if (ovalid) expect_eq(tg("tready during send"), tready, 0);
                    if (held) begin
                        expect_eq(tg("hold ovalid"), ovalid, 1);
                        chk_blk("hold oblock", oblock, h_blk);
                        expect_eq(tg("hold oid"), oid, h_id);
                    end
                    if (ovalid && oready) begin
                        if (q_blk.size() == 0) begin
                            expect_eq(tg("unexpected block"), ovalid, 0);
                        end else begin
                            chk_blk("oblock", oblock, q_blk.pop_front());
                            expect_eq(tg("olen"), olen, q_len.pop_front());
                            expect_eq(tg("oid"), oid, q_id.pop_front());
                            expect_eq(tg("olast"), olast, q_last.pop_front());
                        end
                        held = 1'b0;
                    end else if (ovalid) begin
                        held  = 1'b1;
                        h_blk = oblock;
                        h_id  = oid;
                    end else begin
                        held = 1'b0;
                    end
                end
            end
        end

        initial begin
            logic [7:0] m[$];
            logic [7:0] abc[$];
            int         lens[6];
            abc    = '{8'h61, 8'h62, 8'h63};
            lens   = '{0, BB - LB - 1, BB - LB, BB, BB - 1, 2 * BB + 5};
            rst    = 1'b1;
            tvalid = 1'b0;
            tlast  = 1'b0;
            tid    = '0;
            tdata  = '0;
            tbytes = '0;
            repeat (2) @(negedge clk);
            chk_reset();
            rst = 1'b0;
            @(negedge clk);
            expect_eq(tg("tready after reset"), tready, 1);

            drive_msg(32'h111, abc, 1'b0, 1'b0);
            foreach (lens[i]) begin
                rand_msg(lens[i], m);
                drive_msg(32'h1000 + 32'(i), m, 1'($urandom_range(0, 1)), 1'b0);
            end
            wait_drain();

            // Back-pressure: block must hold still while oready is low.
            stall = 1'b1;
            drive_msg(32'h5, abc, 1'b0, 1'b0);
            repeat (20) @(negedge clk);
            expect_eq(tg("stall ovalid"), ovalid, 1);
            stall = 1'b0;
            wait_drain();

            // Reset in the middle of a message discards it.
            for (int i = 0; i < 3; i++) begin
                tid = 32'h333;
                put_beat(8*IB'($urandom), 1'b0, TBW'(IB));
            end
            rst = 1'b1;
            @(negedge clk);
            chk_reset();
            rst = 1'b0;
            @(negedge clk);
            drive_msg(32'h222, abc, 1'b0, 1'b0);
            wait_drain();

            repeat (20) begin
                rand_msg($urandom_range(0, 3 * BB), m);
                drive_msg($urandom, m, 1'($urandom_range(0, 1)), 1'b0);
            end
            wait_drain();

`ifdef SHA_STREAM_PADDER_ERR_EN
            expect_eq(tg("oerr clean"), oerr, 0);
            if (IB > 1) begin
                rand_msg(2 * IB + 1, m);
                drive_msg(32'h444, m, 1'b0, 1'b1);
                wait_drain();
                expect_eq(tg("oerr sticky"), oerr, 1);
                rst = 1'b1;
                @(negedge clk);
                expect_eq(tg("oerr cleared"), oerr, 0);
                rst = 1'b0;
                @(negedge clk);
            end
`endif
            n_done++;
        end
    end

    initial begin
        fork
            wait (n_done == NCFG);
            #900_000;
        join_any
        if (n_done != NCFG) expect_eq("global timeout", 128'(n_done), 128'(NCFG));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
